// File: rtl/four_bit_program_sequencer_if.sv
// Host-side bus of the 4-bit program sequencer: program load, run control, core drive.
// Adds STEP_MODE_I/STEP_I when SEQ_SINGLE_STEP_EN is defined.
interface four_bit_program_sequencer_if;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 8;

  logic              PROG_WE_I;
  logic [NIB_W-1:0]  PROG_ADDR_I;
  logic [WORD_W-1:0] PROG_DATA_I;
  logic              START_I;
  logic              ABORT_I;
`ifdef SEQ_SINGLE_STEP_EN
  logic              STEP_MODE_I;
  logic              STEP_I;
`endif
  logic              CORE_RST_N_O;
  logic [NIB_W-1:0]  INSTRUCTION_O;
  logic [NIB_W-1:0]  DATA_O;
  logic [NIB_W-1:0]  PC_O;
  logic              BUSY_O;
  logic              DONE_O;
  logic              TIMEOUT_O;

  modport master (
    output PROG_WE_I, PROG_ADDR_I, PROG_DATA_I, START_I, ABORT_I,
    input  CORE_RST_N_O, INSTRUCTION_O, DATA_O, PC_O, BUSY_O, DONE_O, TIMEOUT_O
`ifdef SEQ_SINGLE_STEP_EN
    , output STEP_MODE_I, STEP_I
`endif
  );

  modport slave (
    input  PROG_WE_I, PROG_ADDR_I, PROG_DATA_I, START_I, ABORT_I,
    output CORE_RST_N_O, INSTRUCTION_O, DATA_O, PC_O, BUSY_O, DONE_O, TIMEOUT_O
`ifdef SEQ_SINGLE_STEP_EN
    , input STEP_MODE_I, STEP_I
`endif
  );
endinterface

// File: rtl/four_bit_program_sequencer.sv
// 16-word program sequencer feeding the 4-bit core, two cycles per instruction.
// Optional single-step pause mode is enabled by defining SEQ_SINGLE_STEP_EN.
module four_bit_program_sequencer #(
  parameter int unsigned STEP_LIMIT = 255,
  parameter int unsigned PROG_DEPTH = 16
) (
  input logic                         CLK_I,
  input logic                         RST_I,
  four_bit_program_sequencer_if.slave bus
);
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [NIB_W-1:0] OP_MOV  = 4'd1;
  localparam logic [NIB_W-1:0] OP_ADD  = 4'd2;
  localparam logic [NIB_W-1:0] OP_SUB  = 4'd3;
  localparam logic [NIB_W-1:0] OP_JMP  = 4'd4;
  localparam logic [NIB_W-1:0] OP_JZ   = 4'd5;
  localparam logic [NIB_W-1:0] OP_JNZ  = 4'd6;
  localparam logic [NIB_W-1:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLR, ST_FETCH, ST_ISSUE, ST_DONE
`ifdef SEQ_SINGLE_STEP_EN
    , ST_PAUSE
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] mem [PROG_DEPTH];
  logic [WORD_W-1:0] ir_q, ir_d, fetch_w;
  logic [NIB_W-1:0]  pc_q, pc_d, a_q, a_d, acc_q, acc_d;
  logic [NIB_W-1:0]  ins_q, ins_d, dat_q, dat_d, op, opr;
  logic [CNT_W-1:0]  step_q, step_d, step_inc;
  logic              crn_q, crn_d, busy_q, busy_d, done_q, done_d, to_q, to_d;
  logic              prog_open, at_limit;

  assign op        = ir_q[7:4];
  assign opr       = ir_q[3:0];
  assign fetch_w   = mem[pc_q];
  assign step_inc  = step_q + CNT_W'(1);
  assign at_limit  = (step_inc == CNT_W'(STEP_LIMIT));
  assign prog_open = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // Program store; never reset, writable only while no run is active
  always_ff @(posedge CLK_I) begin
    if (bus.PROG_WE_I && prog_open) mem[bus.PROG_ADDR_I] <= bus.PROG_DATA_I;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (bus.START_I) state_d = ST_CLR;
      ST_CLR:           state_d = ST_FETCH;
      ST_FETCH:         state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (op == OP_HALT || at_limit) state_d = ST_DONE;
`ifdef SEQ_SINGLE_STEP_EN
        else if (bus.STEP_MODE_I)      state_d = ST_PAUSE;
`endif
        else                           state_d = ST_FETCH;
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_PAUSE:         if (bus.STEP_I) state_d = ST_FETCH;
`endif
      default:          state_d = ST_IDLE;
    endcase
    if (bus.ABORT_I) state_d = ST_IDLE;
  end

  // Next values for every registered output and the shadow datapath
  always_comb begin
    pc_d   = pc_q;
    a_d    = a_q;
    acc_d  = acc_q;
    step_d = step_q;
    ir_d   = ir_q;
    to_d   = to_q;
    ins_d  = '0;
    dat_d  = '0;
    crn_d  = (state_d != ST_CLR);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.START_I) begin
          pc_d   = '0;
          a_d    = '0;
          acc_d  = '0;
          step_d = '0;
          to_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        ir_d  = fetch_w;
        ins_d = fetch_w[7] ? '0 : fetch_w[7:4];
        dat_d = fetch_w[3:0];
      end
      ST_ISSUE: begin
        step_d = step_inc;
        pc_d   = pc_q + NIB_W'(1);
        case (op)
          OP_MOV:  a_d   = opr;
          OP_ADD:  acc_d = acc_q + a_q;
          OP_SUB:  acc_d = acc_q - a_q;
          OP_JMP:  pc_d  = a_q;
          OP_JZ:   if (acc_q == '0) pc_d = a_q;
          OP_JNZ:  if (acc_q != '0) pc_d = a_q;
          default: ;
        endcase
        to_d = (op != OP_HALT) && at_limit;
      end
      default: ;
    endcase
    // Abort leaves the core running but clears what the host sees
    if (bus.ABORT_I) begin
      pc_d  = '0;
      to_d  = 1'b0;
      ins_d = '0;
      dat_d = '0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      pc_q   <= '0;
      a_q    <= '0;
      acc_q  <= '0;
      step_q <= '0;
      ir_q   <= '0;
      ins_q  <= '0;
      dat_q  <= '0;
      crn_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      a_q    <= a_d;
      acc_q  <= acc_d;
      step_q <= step_d;
      ir_q   <= ir_d;
      ins_q  <= ins_d;
      dat_q  <= dat_d;
      crn_q  <= crn_d;
      busy_q <= busy_d;
      done_q <= done_d;
      to_q   <= to_d;
    end
  end

  assign bus.CORE_RST_N_O  = crn_q;
  assign bus.INSTRUCTION_O = ins_q;
  assign bus.DATA_O        = dat_q;
  assign bus.PC_O          = pc_q;
  assign bus.BUSY_O        = busy_q;
  assign bus.DONE_O        = done_q;
  assign bus.TIMEOUT_O     = to_q;
endmodule

// File: tb/tb_four_bit_program_sequencer.sv
// Bench for four_bit_program_sequencer: two instances (step limits 255 and 16) run
// the same programs and are compared cycle by cycle against an instruction-level model.
module tb_four_bit_program_sequencer;
  localparam int unsigned LIM_A = 255;
  localparam int unsigned LIM_B = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  four_bit_program_sequencer_if if_a ();
  four_bit_program_sequencer_if if_b ();

  four_bit_program_sequencer #(.STEP_LIMIT(LIM_A), .PROG_DEPTH(16)) dut_a (
    .CLK_I(clk), .RST_I(rst), .bus(if_a.slave));
  four_bit_program_sequencer #(.STEP_LIMIT(LIM_B), .PROG_DEPTH(16)) dut_b (
    .CLK_I(clk), .RST_I(rst), .bus(if_b.slave));

  int total = 0;
  int bad   = 0;

  logic [7:0] prog  [16];
  logic [7:0] mem_m [16];
  logic [3:0] e_ins [2][256];
  logic [3:0] e_dat [2][256];
  logic [3:0] e_pca [2][256];
  int         e_n   [2];
  logic [3:0] e_pc  [2];
  logic       e_to  [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed view: {core_rst_n, busy, done, timeout, pc, instruction, data}
  function automatic logic [15:0] obs(input int d);
    if (d == 0)
      return {if_a.CORE_RST_N_O, if_a.BUSY_O, if_a.DONE_O, if_a.TIMEOUT_O,
              if_a.PC_O, if_a.INSTRUCTION_O, if_a.DATA_O};
    return {if_b.CORE_RST_N_O, if_b.BUSY_O, if_b.DONE_O, if_b.TIMEOUT_O,
            if_b.PC_O, if_b.INSTRUCTION_O, if_b.DATA_O};
  endfunction

  task automatic drv(input logic we, input logic [3:0] ad, input logic [7:0] dt,
                     input logic st, input logic ab);
    if_a.PROG_WE_I = we; if_a.PROG_ADDR_I = ad; if_a.PROG_DATA_I = dt;
    if_a.START_I = st;   if_a.ABORT_I = ab;
    if_b.PROG_WE_I = we; if_b.PROG_ADDR_I = ad; if_b.PROG_DATA_I = dt;
    if_b.START_I = st;   if_b.ABORT_I = ab;
  endtask

  // Instruction-level execution of the stored program, one entry per issued word
  task automatic model(input int d, input int lim);
    logic [3:0] pc, a, acc, op, opr;
    bit halt;
    int n;
    pc = 4'd0; a = 4'd0; acc = 4'd0; halt = 1'b0; n = 0;
    while (!halt && n < lim) begin
      op  = mem_m[pc][7:4];
      opr = mem_m[pc][3:0];
      e_pca[d][n] = pc;
      e_ins[d][n] = (op >= 4'd8) ? 4'd0 : op;
      e_dat[d][n] = opr;
      n++;
      halt = (op == 4'hF);
      case (op)
        4'd1: begin a = opr; pc = pc + 4'd1; end
        4'd2: begin acc = acc + a; pc = pc + 4'd1; end
        4'd3: begin acc = acc - a; pc = pc + 4'd1; end
        4'd4: pc = a;
        4'd5: pc = (acc == 4'd0) ? a : pc + 4'd1;
        4'd6: pc = (acc != 4'd0) ? a : pc + 4'd1;
        default: pc = pc + 4'd1;
      endcase
    end
    e_n[d]  = n;
    e_pc[d] = pc;
    e_to[d] = !halt;
  endtask

  // Expected outputs in cycle j after the START edge (j=1 is the core-clear cycle)
  function automatic logic [15:0] exp_word(input int d, input int j);
    int n, k;
    logic [3:0] pc, ins, dat;
    logic crn, busy, done, to;
    n = e_n[d];
    pc = 4'd0; ins = 4'd0; dat = 4'd0;
    crn = 1'b1; busy = 1'b0; done = 1'b0; to = 1'b0;
    if (j == 1) begin
      crn = 1'b0; busy = 1'b1;
    end else if (j <= 2 * n + 1) begin
      busy = 1'b1;
      k = (j - 2) / 2;
      pc = e_pca[d][k];
      if (j % 2 == 1) begin
        ins = e_ins[d][k];
        dat = e_dat[d][k];
      end
    end else begin
      done = 1'b1; pc = e_pc[d]; to = e_to[d];
    end
    return {crn, busy, done, to, pc, ins, dat};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 4'(i), prog[i], 1'b0, 1'b0);
      mem_m[i] = prog[i];
      @(negedge clk);
    end
    drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic set_prog(input logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3;
    prog[4] = w4; prog[5] = w5; prog[6] = w6; prog[7] = w7;
  endtask

  // One run; cut_j>0 aborts (or resets if cut_rst) during cycle cut_j,
  // wr_j>0 attempts a write of 0xF0 to address 0 during cycle wr_j
  task automatic run(input int cut_j, input bit cut_rst, input int wr_j);
    int jmax;
    model(0, LIM_A);
    model(1, LIM_B);
    jmax = 2 * ((e_n[0] > e_n[1]) ? e_n[0] : e_n[1]) + 3;
    drv(1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    for (int j = 1; j <= jmax; j++) begin
      chk($sformatf("cyc_a_j%0d", j), obs(0), exp_word(0, j));
      chk($sformatf("cyc_b_j%0d", j), obs(1), exp_word(1, j));
      if (j == cut_j) begin
        if (cut_rst) begin
          rst = 1'b1;
          drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        end else begin
          drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
        end
        @(negedge clk);
        chk(cut_rst ? "rst_cut_a" : "abort_cut_a", obs(0), cut_rst ? 16'h0000 : 16'h8000);
        chk(cut_rst ? "rst_cut_b" : "abort_cut_b", obs(1), cut_rst ? 16'h0000 : 16'h8000);
        rst = 1'b0;
        drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("after_cut_a", obs(0), 16'h8000);
        chk("after_cut_b", obs(1), 16'h8000);
        return;
      end
      if (j == wr_j) drv(1'b1, 4'd0, 8'hF0, 1'b0, 1'b0);
      else           drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    int sel;
    rst = 1'b1;
    drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
`ifdef SEQ_SINGLE_STEP_EN
    if_a.STEP_MODE_I = 1'b0; if_a.STEP_I = 1'b0;
    if_b.STEP_MODE_I = 1'b0; if_b.STEP_I = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_a", obs(0), 16'h0000);
    chk("reset_b", obs(1), 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_a", obs(0), 16'h8000);
    chk("post_reset_b", obs(1), 16'h8000);

    // Straight line
    set_prog(8'h13, 8'h20, 8'h70, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
    load_prog();
    run(0, 1'b0, 0);

    // Countdown loop (exceeds the 16-step limit of dut_b)
    set_prog(8'h13, 8'h20, 8'h11, 8'h30, 8'h70, 8'h12, 8'h60, 8'hF0);
    load_prog();
    run(0, 1'b0, 0);

    // Endless loop: timeout, then rerun clears the flag at start
    set_prog(8'h10, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    load_prog();
    run(0, 1'b0, 0);
    run(0, 1'b0, 0);

    // Abort and reset during the third ISSUE
    set_prog(8'h13, 8'h20, 8'h70, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
    load_prog();
    run(7, 1'b0, 0);
    run(7, 1'b1, 0);

    // Write while busy is dropped; write in DONE lands
    run(0, 1'b0, 4);
    drv(1'b1, 4'd0, 8'hF0, 1'b0, 1'b0);
    mem_m[0] = 8'hF0;
    @(negedge clk);
    drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    run(0, 1'b0, 0);

    // Random programs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        sel = int'($urandom_range(0, 9));
        if (sel <= 7)      prog[i] = {4'(sel), 4'($urandom_range(0, 15))};
        else if (sel == 8) prog[i] = {4'($urandom_range(8, 14)), 4'h0};
        else               prog[i] = 8'hF0;
      end
      load_prog();
      run(0, 1'b0, 0);
    end

`ifdef SEQ_SINGLE_STEP_EN
    set_prog(8'h13, 8'h20, 8'h70, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
    load_prog();
    model(0, LIM_A);
    if_a.STEP_MODE_I = 1'b1;
    drv(1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("step_issue0", obs(0), exp_word(0, 3));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("step_pause_c%0d", c), obs(0), {4'b1100, e_pca[0][1], 8'h00});
    end
    if_a.STEP_I = 1'b1;
    @(negedge clk);
    if_a.STEP_I = 1'b0;
    if_a.STEP_MODE_I = 1'b0;
    @(negedge clk);
    chk("step_issue1", obs(0), exp_word(0, 5));
    drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drv(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    chk("step_abort", obs(0), 16'h8000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
